conv_mac_ctrl: RTL and testbench

Sequencer that drives one `mac_pipe` accumulator to compute a 2D valid-mode convolution of an R×C input matrix X with a K×K kernel W plus a scalar bias. It issues synchronous-read addresses to the X and W memories and feeds the MAC's operand, init, and valid inputs with the MAC's 2-cycle product/accumulate pipeline in mind. It returns each finished sum on a valid/ready output stream. It sits between the X/W memories and the downstream output buffer.

---
 rtl/conv_mac_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_conv_mac_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_ctrl.sv
// conv_mac_ctrl: walks X/W taps into a 2-stage MAC for valid-mode 2D
// convolution and streams each finished sum out on a valid/ready port.
module conv_mac_ctrl #(
    parameter int INW  = 12,
    parameter int OUTW = 48,
    parameter int R    = 9,
    parameter int C    = 8,
    parameter int K    = 4,
    localparam int XAW = (R * C > 1) ? $clog2(R * C) : 1,
    localparam int WAW = (K * K > 1) ? $clog2(K * K) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic signed [INW-1:0]  b_data,
    output logic                   busy,
    output logic                   done,
    output logic        [XAW-1:0]  x_addr,
    input  logic signed [INW-1:0]  x_data,
    output logic        [WAW-1:0]  w_addr,
    input  logic signed [INW-1:0]  w_data,
    output logic signed [INW-1:0]  mac_in0,
    output logic signed [INW-1:0]  mac_in1,
    output logic signed [INW-1:0]  mac_init_value,
    output logic                   mac_init_acc,
    output logic                   mac_input_valid,
    input  logic signed [OUTW-1:0] mac_out,
    output logic signed [OUTW-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int RW = $clog2(R + 1);
    localparam int CW = $clog2(C + 1);
    localparam int KW = $clog2(K + 1);
    localparam int TW = $clog2(K * K + 1);

    localparam logic [RW-1:0]  R_LAST = RW'(R - K);
    localparam logic [CW-1:0]  C_LAST = CW'(C - K);
    localparam logic [KW-1:0]  K_LAST = KW'(K - 1);
    localparam logic [TW-1:0]  T_LAST = TW'(K * K - 1);
    localparam logic [XAW-1:0] C_MUL  = XAW'(C);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        FEED,
        DRAIN,
        OUT
    } state_e;

    state_e state_q, state_d;

    logic [RW-1:0]         r_q, r_d;
    logic [CW-1:0]         c_q, c_d;
    logic [KW-1:0]         i_q, i_d;
    logic [KW-1:0]         j_q, j_d;
    logic [TW-1:0]         tap_q, tap_d;
    logic                  drain_q, drain_d;
    logic                  valid_q, valid_d;
    logic                  done_q, done_d;
    logic signed [INW-1:0] bias_q, bias_d;
    logic [XAW-1:0]        x_addr_q, x_addr_d;
    logic [WAW-1:0]        w_addr_q, w_addr_d;
    logic                  load;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            r_q      <= '0;
            c_q      <= '0;
            i_q      <= '0;
            j_q      <= '0;
            tap_q    <= '0;
            drain_q  <= 1'b0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            bias_q   <= '0;
            x_addr_q <= '0;
            w_addr_q <= '0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            c_q      <= c_d;
            i_q      <= i_d;
            j_q      <= j_d;
            tap_q    <= tap_d;
            drain_q  <= drain_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            bias_q   <= bias_d;
            x_addr_q <= x_addr_d;
            w_addr_q <= w_addr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        c_d      = c_q;
        i_d      = i_q;
        j_d      = j_q;
        tap_d    = tap_q;
        drain_d  = drain_q;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        bias_d   = bias_q;
        x_addr_d = x_addr_q;
        w_addr_d = w_addr_q;
        load     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = INIT;
                    bias_d  = b_data;
                    r_d     = '0;
                    c_d     = '0;
                    i_d     = '0;
                    j_d     = '0;
                    tap_d   = '0;
                    load    = 1'b1;
                end
            end
            INIT, FEED: begin
                valid_d = 1'b1;
                if (tap_q == T_LAST) begin
                    state_d = DRAIN;
                    drain_d = 1'b0;
                end else begin
                    state_d = FEED;
                    tap_d   = tap_q + TW'(1);
                    load    = 1'b1;
                    if (j_q == K_LAST) begin
                        j_d = '0;
                        i_d = i_q + KW'(1);
                    end else begin
                        j_d = j_q + KW'(1);
                    end
                end
            end
            DRAIN: begin
                // two cycles lets the last product land in the accumulator
                drain_d = 1'b1;
                if (drain_q) state_d = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    if (r_q == R_LAST && c_q == C_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = INIT;
                        i_d     = '0;
                        j_d     = '0;
                        tap_d   = '0;
                        load    = 1'b1;
                        if (c_q == C_LAST) begin
                            c_d = '0;
                            r_d = r_q + RW'(1);
                        end else begin
                            c_d = c_q + CW'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // addresses are registered one cycle ahead of the state that uses them
        if (load) begin
            x_addr_d = (XAW'(r_d) + XAW'(i_d)) * C_MUL
                     + XAW'(c_d) + XAW'(j_d);
            w_addr_d = WAW'(tap_d);
        end
    end

    assign busy            = (state_q != IDLE);
    assign done            = done_q;
    assign x_addr          = x_addr_q;
    assign w_addr          = w_addr_q;
    assign mac_in0         = x_data;
    assign mac_in1         = w_data;
    assign mac_init_value  = bias_q;
    assign mac_init_acc    = (state_q == INIT);
    assign mac_input_valid = valid_q;
    assign out_data        = mac_out;
    assign out_valid       = (state_q == OUT);

endmodule

// File: tb/tb_conv_mac_ctrl.sv
// Directed bench for conv_mac_ctrl: two instances (4x4/K=2 and 2x2/K=1)
// each with its own X/W memories and 2-stage MAC model.
module tb_conv_mac_ctrl;

    localparam int INW   = 12;
    localparam int OUTW  = 48;
    localparam int XAW_A = 4;
    localparam int WAW_A = 2;
    localparam int XAW_B = 2;
    localparam int WAW_B = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic                   start_a = 1'b0, ready_a = 1'b1;
    logic signed [INW-1:0]  bias_a = '0;
    logic                   busy_a, done_a, mia_a, miv_a, ov_a;
    logic [XAW_A-1:0]       xad_a;
    logic [WAW_A-1:0]       wad_a;
    logic signed [INW-1:0]  xd_a, wd_a, in0_a, in1_a, iv_a;
    logic signed [OUTW-1:0] acc_a, od_a;
    logic signed [INW-1:0]  xa [0:15];
    logic signed [INW-1:0]  wa [0:3];

    logic                   start_b = 1'b0, ready_b = 1'b1;
    logic signed [INW-1:0]  bias_b = '0;
    logic                   busy_b, done_b, mia_b, miv_b, ov_b;
    logic [XAW_B-1:0]       xad_b;
    logic [WAW_B-1:0]       wad_b;
    logic signed [INW-1:0]  xd_b, wd_b, in0_b, in1_b, iv_b;
    logic signed [OUTW-1:0] acc_b, od_b;
    logic signed [INW-1:0]  xb [0:3];
    logic signed [INW-1:0]  wb [0:1];

    conv_mac_ctrl #(.INW(INW), .OUTW(OUTW), .R(4), .C(4), .K(2)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .b_data(bias_a),
        .busy(busy_a), .done(done_a), .x_addr(xad_a), .x_data(xd_a),
        .w_addr(wad_a), .w_data(wd_a), .mac_in0(in0_a), .mac_in1(in1_a),
        .mac_init_value(iv_a), .mac_init_acc(mia_a),
        .mac_input_valid(miv_a), .mac_out(acc_a), .out_data(od_a),
        .out_valid(ov_a), .out_ready(ready_a)
    );

    conv_mac_ctrl #(.INW(INW), .OUTW(OUTW), .R(2), .C(2), .K(1)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .b_data(bias_b),
        .busy(busy_b), .done(done_b), .x_addr(xad_b), .x_data(xd_b),
        .w_addr(wad_b), .w_data(wd_b), .mac_in0(in0_b), .mac_in1(in1_b),
        .mac_init_value(iv_b), .mac_init_acc(mia_b),
        .mac_input_valid(miv_b), .mac_out(acc_b), .out_data(od_b),
        .out_valid(ov_b), .out_ready(ready_b)
    );

    // synchronous-read memories
    always @(posedge clk) begin
        xd_a <= xa[xad_a];
        wd_a <= wa[wad_a];
        xd_b <= xb[xad_b];
        wd_b <= wb[wad_b];
    end

    // MAC model: product register, then accumulate
    logic signed [2*INW-1:0] pa_q, pb_q;
    logic pva_q, pvb_q;
    always @(posedge clk) begin
        if (reset) begin
            pa_q <= '0; pva_q <= 1'b0; acc_a <= '0;
            pb_q <= '0; pvb_q <= 1'b0; acc_b <= '0;
        end else begin
            pa_q  <= in0_a * in1_a;
            pva_q <= miv_a;
            if (mia_a) acc_a <= {{(OUTW-INW){iv_a[INW-1]}}, iv_a};
            else if (pva_q)
                acc_a <= acc_a + {{(OUTW-2*INW){pa_q[2*INW-1]}}, pa_q};
            pb_q  <= in0_b * in1_b;
            pvb_q <= miv_b;
            if (mia_b) acc_b <= {{(OUTW-INW){iv_b[INW-1]}}, iv_b};
            else if (pvb_q)
                acc_b <= acc_b + {{(OUTW-2*INW){pb_q[2*INW-1]}}, pb_q};
        end
    end

    bit use_b = 1'b0;
    logic s_busy, s_done, s_init, s_iv, s_ov;
    logic signed [OUTW-1:0] s_data;
    assign s_busy = use_b ? busy_b : busy_a;
    assign s_done = use_b ? done_b : done_a;
    assign s_init = use_b ? mia_b  : mia_a;
    assign s_iv   = use_b ? miv_b  : miv_a;
    assign s_ov   = use_b ? ov_b   : ov_a;
    assign s_data = use_b ? od_b   : od_a;

    int     n_got, done_cyc, first_ov, init_cyc, iv_first, iv_cnt;
    int     busy_at_done;
    longint got [0:15];
    int     got_cyc [0:15];
    longint exp3 [0:8];

    task automatic check(input string tag, input longint obs,
                         input longint expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic set_ready(input bit b, input logic v);
        if (b) ready_b = v;
        else ready_a = v;
    endtask

    task automatic run(input bit b, input int hold, input int restart_at,
                       input int limit);
        int cyc;
        int left;
        longint held;
        use_b = b;
        n_got = 0; done_cyc = -1; first_ov = -1; init_cyc = -1;
        iv_first = -1; iv_cnt = 0; busy_at_done = -1;
        for (int k = 0; k < 16; k++) begin
            got[k] = 64'hDEAD; got_cyc[k] = -1;
        end
        left = hold; cyc = 0; held = 0;
        @(negedge clk);
        start_a = !b; start_b = b;
        ready_a = 1'b1; ready_b = 1'b1;
        while (cyc < limit && done_cyc < 0) begin
            @(negedge clk);
            cyc++;
            start_a = !b && (cyc == restart_at);
            start_b = b && (cyc == restart_at);
            if (s_init && init_cyc < 0) init_cyc = cyc;
            if (s_iv && first_ov < 0) begin
                if (iv_first < 0) iv_first = cyc;
                iv_cnt++;
            end
            if (s_ov) begin
                if (first_ov < 0) first_ov = cyc;
                if (left > 0) begin
                    if (left == hold) held = s_data;
                    else check("hold_data", s_data, held);
                    check("hold_mac_valid", longint'(s_iv), 0);
                    left--;
                    set_ready(b, 1'b0);
                end else begin
                    set_ready(b, 1'b1);
                    if (n_got < 16) begin
                        got[n_got] = s_data;
                        got_cyc[n_got] = cyc;
                    end
                    n_got++;
                end
            end
            if (s_done) begin
                done_cyc = cyc;
                busy_at_done = int'(s_busy);
            end
        end
        start_a = 1'b0; start_b = 1'b0;
        ready_a = 1'b1; ready_b = 1'b1;
        check("done_within_budget", longint'(done_cyc >= 0), 1);
    endtask

    task automatic check_idle_a(input string tag);
        check({tag, "_busy"}, longint'(busy_a), 0);
        check({tag, "_done"}, longint'(done_a), 0);
        check({tag, "_out_valid"}, longint'(ov_a), 0);
        check({tag, "_init_acc"}, longint'(mia_a), 0);
        check({tag, "_input_valid"}, longint'(miv_a), 0);
        check({tag, "_x_addr"}, longint'(xad_a), 0);
        check({tag, "_w_addr"}, longint'(wad_a), 0);
        check({tag, "_init_value"}, longint'(iv_a), 0);
    endtask

    task automatic load_ones;
        for (int k = 0; k < 16; k++) xa[k] = 12'sd1;
        for (int k = 0; k < 4; k++) wa[k] = 12'sd1;
        bias_a = 12'sd0;
    endtask

    task automatic load_ramp;
        for (int k = 0; k < 16; k++) xa[k] = INW'(k);
        for (int k = 0; k < 4; k++) wa[k] = INW'(k + 1);
        bias_a = 12'sd10;
    endtask

    initial begin
        int cnt;
        exp3 = '{44, 54, 64, 84, 94, 104, 124, 134, 144};
        xb = '{12'sd1, 12'sd2, 12'sd3, 12'sd4};
        wb = '{12'sd7, 12'sd0};
        bias_b = 12'sd1;
        load_ones();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_idle_a("reset");

        // ones: 9 outputs of 4, timing reference
        run(1'b0, 0, -1, 200);
        check("t1_init_cycle", init_cyc, 1);
        check("t1_valid_first", iv_first, 2);
        check("t1_valid_count", iv_cnt, 4);
        check("t1_first_out", first_ov, 7);
        check("t1_count", n_got, 9);
        for (int k = 0; k < 9; k++) check("t1_data", got[k], 4);
        check("t1_period", got_cyc[1] - got_cyc[0], 7);
        check("t1_done_cycle", done_cyc, 64);
        check("t1_busy_at_done", busy_at_done, 0);

        // negative operands
        for (int k = 0; k < 16; k++) xa[k] = -12'sd3;
        for (int k = 0; k < 4; k++) wa[k] = 12'sd5;
        bias_a = -12'sd2;
        run(1'b0, 0, -1, 200);
        check("t2_count", n_got, 9);
        for (int k = 0; k < 9; k++) check("t2_data", got[k], -62);

        // ramp input, distinct kernel weights
        load_ramp();
        run(1'b0, 0, -1, 200);
        check("t3_count", n_got, 9);
        for (int k = 0; k < 9; k++) check("t3_data", got[k], exp3[k]);

        // backpressure on output 0 for 5 cycles
        load_ones();
        run(1'b0, 5, -1, 300);
        check("t4_first_out", first_ov, 7);
        check("t4_first_hs", got_cyc[0], 12);
        check("t4_count", n_got, 9);
        for (int k = 0; k < 9; k++) check("t4_data", got[k], 4);
        check("t4_done_cycle", done_cyc, 69);

        // stray start during FEED
        run(1'b0, 0, 3, 200);
        check("t5_count", n_got, 9);
        for (int k = 0; k < 9; k++) check("t5_data", got[k], 4);
        check("t5_done_cycle", done_cyc, 64);

        // reset during FEED
        load_ramp();
        use_b = 1'b0;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("r_feed_busy", longint'(busy_a), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle_a("midreset");
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (ov_a || done_a) cnt++;
        end
        check("r_no_out_or_done", cnt, 0);
        run(1'b0, 0, -1, 200);
        check("r_count", n_got, 9);
        for (int k = 0; k < 9; k++) check("r_data", got[k], exp3[k]);

        // K=1, 2x2
        run(1'b1, 0, -1, 100);
        check("k1_first_out", first_ov, 4);
        check("k1_count", n_got, 4);
        check("k1_data0", got[0], 8);
        check("k1_data1", got[1], 15);
        check("k1_data2", got[2], 22);
        check("k1_data3", got[3], 29);
        check("k1_period", got_cyc[1] - got_cyc[0], 4);
        check("k1_done_cycle", done_cyc, 17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
